ps2_rx_fifo: RTL

Parametrised PS/2 device-to-host receiver for the VGA/mouse subsystem. It filters the PS/2 clock, deserialises 11-bit frames, and checks start, stop and (optionally) odd-parity bits. A per-frame inactivity watchdog aborts stalled frames. Accepted bytes are buffered in a first-word-fall-through FIFO so the mouse/keyboard decoder can drain packets at its own pace.

---
 rtl/ps2_rx_fifo.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 device-to-host receiver with glitch filter, frame watchdog and FWFT byte FIFO
// Optional odd-parity checking is enabled by defining PS2_RX_PARITY_CHECK_EN.
module ps2_rx_fifo #(
  parameter int FILTER_LEN  = 8,
  parameter int FIFO_AW     = 2,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  input  logic       rd_en,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full,
  output logic       rx_done_tick,
  output logic       parity_err,
  output logic       frame_err,
  output logic       timeout_err,
  output logic       overflow
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int WD_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [WD_W-1:0]    WD_MAX   = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [WD_W-1:0]    WD_ONE   = WD_W'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DPS  = 2'd1,
    CHK  = 2'd2
  } state_t;

  logic [FILTER_LEN-1:0] r_filter;
  logic                  r_f_ps2c;
  logic                  w_f_ps2c_next;
  logic                  w_fall;

  state_t                r_state;
  state_t                w_state_next;
  logic [3:0]            r_n;
  logic [3:0]            w_n_next;
  logic [9:0]            r_shift;
  logic [9:0]            w_shift_next;
  logic [WD_W-1:0]       r_wdog;
  logic [WD_W-1:0]       w_wdog_next;

  logic [7:0]            r_mem [DEPTH];
  logic [FIFO_AW-1:0]    r_wptr;
  logic [FIFO_AW-1:0]    r_rptr;
  logic [FIFO_AW:0]      r_count;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_can_push;

  // Filtered clock only changes once the whole window agrees; partial windows hold.
  always_comb begin
    w_f_ps2c_next = r_f_ps2c;
    if (&r_filter)
      w_f_ps2c_next = 1'b1;
    else if (~|r_filter)
      w_f_ps2c_next = 1'b0;
  end

  assign w_fall = r_f_ps2c & ~w_f_ps2c_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_filter <= '0;
      r_f_ps2c <= 1'b0;
    end else begin
      r_filter <= {ps2c, r_filter[FILTER_LEN-1:1]};
      r_f_ps2c <= w_f_ps2c_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_n     <= '0;
      r_shift <= '0;
      r_wdog  <= '0;
    end else begin
      r_state <= w_state_next;
      r_n     <= w_n_next;
      r_shift <= w_shift_next;
      r_wdog  <= w_wdog_next;
    end
  end

  assign w_can_push = ~full | rd_en;

  always_comb begin
    w_state_next = r_state;
    w_n_next     = r_n;
    w_shift_next = r_shift;
    w_wdog_next  = r_wdog;
    w_push       = 1'b0;
    rx_done_tick = 1'b0;
    parity_err   = 1'b0;
    frame_err    = 1'b0;
    timeout_err  = 1'b0;
    overflow     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fall && rx_en && !ps2d) begin
          w_n_next     = 4'd9;
          w_wdog_next  = '0;
          w_state_next = DPS;
        end
      end
      DPS: begin
        // r_shift ends up as {stop, parity, d7..d0} after the tenth edge.
        if (w_fall) begin
          w_shift_next = {ps2d, r_shift[9:1]};
          w_wdog_next  = '0;
          if (r_n == 4'd0)
            w_state_next = CHK;
          else
            w_n_next = r_n - 4'd1;
        end else if (r_wdog == WD_MAX) begin
          timeout_err  = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_wdog_next = r_wdog + WD_ONE;
        end
      end
      CHK: begin
        w_state_next = IDLE;
        if (!r_shift[9])
          frame_err = 1'b1;
`ifdef PS2_RX_PARITY_CHECK_EN
        else if (~^r_shift[8:0])
          parity_err = 1'b1;
`endif
        else if (!w_can_push)
          overflow = 1'b1;
        else begin
          w_push       = 1'b1;
          rx_done_tick = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign empty = (r_count == '0);
  assign full  = (r_count == CNT_FULL);
  assign w_pop = rd_en & ~empty;
  // Memory is not reset, so the head is masked to keep dout at zero while empty.
  assign dout  = empty ? 8'h00 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr] <= r_shift[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)
        r_rptr <= r_rptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
